rcvr_param: RTL and testbench



---
 rtl/rcvr_param.sv | 143 ++++++++++++++
 tb/tb_rcvr_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcvr_param.sv
// rcvr_param: parametrised serial frame receiver.
// Hunts the serial stream for HDR_PATTERN with a sliding window, shifts in a
// DATA_W-bit payload MSB-first, optionally checks one parity bit, and then
// hands the word to a parallel consumer.
//
// Handshake: ready=1 means data_out/parity_err hold an unread word. The
// consumer pulses reading for one cycle to take it. A delivery in the same
// cycle as reading wins (ready stays 1) and the old word counts as consumed.
// A delivery while ready=1 and no reading sets overrun, which stays set
// until the next reading.
module rcvr_param #(
  parameter int               HDR_W       = 8,
  parameter logic [HDR_W-1:0] HDR_PATTERN = HDR_W'(8'hA5),
  parameter int               DATA_W      = 8,
  parameter int               PARITY_EN   = 1,
  parameter int               PARITY_ODD  = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              data_in,
  input  logic              bit_valid,
  input  logic              reading,
  output logic              ready,
  output logic              overrun,
  output logic              parity_err,
  output logic [DATA_W-1:0] data_out
);

  localparam int   FILL_W = $clog2(HDR_W + 1);
  localparam int   CNT_W  = $clog2(DATA_W + 1);
  localparam logic ODD    = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    BODY   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  // Only the most recent HDR_W-1 bits need storing; the current bit completes the window.
  logic [HDR_W-2:0]  window;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] body_sr;

  logic [HDR_W-1:0]  window_next;
  logic [DATA_W-1:0] body_next;
  logic              hdr_match;
  logic              last_body;
  logic              parity_bad;

  assign window_next = {window, data_in};

  if (DATA_W > 1) begin : g_shift_wide
    assign body_next = {body_sr[DATA_W-2:0], data_in};
  end else begin : g_shift_one
    assign body_next = data_in;
  end

  assign hdr_match  = (fill >= FILL_W'(HDR_W - 1)) && (window_next == HDR_PATTERN);
  assign last_body  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign parity_bad = ((^body_sr) ^ data_in) != ODD;

  logic              deliver;
  logic [DATA_W-1:0] deliver_word;
  logic              deliver_perr;

  // Decide whether the bit sampled at this edge completes a frame.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = body_sr;
    deliver_perr = 1'b0;
    if (bit_valid) begin
      case (state)
        BODY: begin
          if (last_body && (PARITY_EN == 0)) begin
            deliver      = 1'b1;
            deliver_word = body_next;
          end
        end
        PARITY: begin
          deliver      = 1'b1;
          deliver_perr = parity_bad;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM, shift registers and the registered consumer-side outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= HUNT;
      window     <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      body_sr    <= '0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      data_out   <= '0;
    end else begin
      if (bit_valid) begin
        case (state)
          HUNT: begin
            if (hdr_match) begin
              state   <= BODY;
              bit_cnt <= '0;
              window  <= '0;
              fill    <= '0;
            end else begin
              window <= window_next[HDR_W-2:0];
              if (fill != FILL_W'(HDR_W)) fill <= fill + 1'b1;
            end
          end
          BODY: begin
            body_sr <= body_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_body) state <= (PARITY_EN != 0) ? PARITY : HUNT;
          end
          PARITY: begin
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end

      if (deliver) begin
        data_out   <= deliver_word;
        parity_err <= deliver_perr;
      end

      if (deliver)      ready <= 1'b1;
      else if (reading) ready <= 1'b0;

      if (reading)               overrun <= 1'b0;
      else if (deliver && ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rcvr_param.sv
// Testbench for rcvr_param: directed scenarios followed by randomized framed
// traffic, checked every cycle against a bit-queue reference model.
module tb_rcvr_param;

  localparam int         HDR_W       = 8;
  localparam logic [7:0] HDR_PATTERN = 8'hA5;
  localparam int         DATA_W      = 8;
  localparam int         PARITY_EN   = 1;
  localparam int         PARITY_ODD  = 0;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              data_in;
  logic              bit_valid;
  logic              reading;
  logic              ready;
  logic              overrun;
  logic              parity_err;
  logic [DATA_W-1:0] data_out;

  rcvr_param #(
    .HDR_W(HDR_W), .HDR_PATTERN(HDR_PATTERN), .DATA_W(DATA_W),
    .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .bit_valid(bit_valid),
    .reading(reading), .ready(ready), .overrun(overrun),
    .parity_err(parity_err), .data_out(data_out)
  );

  // Clock
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: header history and payload kept as plain bit queues.
  bit          hist[$];
  bit          pay[$];
  bit          in_frame;
  logic        m_ready, m_ov, m_perr;
  logic [7:0]  m_data;
  logic [8:0]  exp_q[$];

  task automatic model_edge(input bit rst_n, input bit d, input bit v, input bit rd);
    bit         del;
    logic [7:0] w;
    bit         pe;
    int         hv;
    del = 0; w = 0; pe = 0;
    if (!rst_n) begin
      hist.delete(); pay.delete(); in_frame = 0;
      m_ready = 0; m_ov = 0; m_perr = 0; m_data = 0;
      return;
    end
    if (v) begin
      if (!in_frame) begin
        hist.push_back(d);
        if (hist.size() > HDR_W) void'(hist.pop_front());
        hv = 0;
        foreach (hist[i]) hv = (hv << 1) | int'(hist[i]);
        if (hist.size() == HDR_W && hv == int'(HDR_PATTERN)) begin
          in_frame = 1; hist.delete(); pay.delete();
        end
      end else begin
        pay.push_back(d);
        if (pay.size() == DATA_W + PARITY_EN) begin
          for (int i = 0; i < DATA_W; i++) w = {w[6:0], pay[i]};
          if (PARITY_EN != 0) pe = ((^w) ^ pay[DATA_W]) != (PARITY_ODD != 0);
          del = 1; in_frame = 0; pay.delete();
        end
      end
    end
    if (rd) m_ov = 0;
    else if (del && m_ready) m_ov = 1;
    if (del) m_ready = 1;
    else if (rd) m_ready = 0;
    if (del) begin
      m_data = w; m_perr = pe;
      exp_q.push_back({pe, w});
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input bit d, input bit v, input bit rd, input bit rst_n = 1'b1);
    logic [8:0] e;
    reset_n = rst_n; data_in = d; bit_valid = v; reading = rd;
    @(posedge clock);
    model_edge(rst_n, d, v, rd);
    #1;
    check("ready", ready, m_ready);
    check("overrun", overrun, m_ov);
    check("data_out", data_out, m_data);
    check("parity_err", parity_err, m_perr);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_word", data_out, e[7:0]);
      check("sb_perr", parity_err, e[8]);
    end
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit gap, input bit rd_last);
    for (int i = n - 1; i >= 0; i--) begin
      step(val[i], 1'b1, (i == 0) && rd_last);
      if (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input bit par, input bit gap, input bit rd_last);
    send_bits(32'(HDR_PATTERN), 8, gap, 1'b0);
    send_bits(32'(w), 8, gap, 1'b0);
    send_bits(32'(par), 1, gap, rd_last);
  endtask

  task automatic clear_read();
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Random bit with random qualifier gaps and random reads.
  task automatic rand_bit(input bit d);
    while ($urandom_range(0, 3) == 0) step(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 4) == 0);
    step(d, 1'b1, $urandom_range(0, 4) == 0);
  endtask

  initial begin
    logic [7:0] w;
    reset_n = 0; data_in = 0; bit_valid = 0; reading = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_ready", ready, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", data_out, 0);
    check("rst_perr", parity_err, 0);

    // Basic frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("basic_ready", ready, 1);
    check("basic_data", data_out, 8'h3C);
    check("basic_perr", parity_err, 0);
    check("basic_ov", overrun, 0);
    clear_read();

    // Overlapping false start before the header
    send_bits(32'b10101, 5, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    check("overlap_data", data_out, 8'h0F);
    check("overlap_perr", parity_err, 0);
    clear_read();

    // Gapped bits
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("gap_data", data_out, 8'h3C);
    check("gap_ready", ready, 1);
    clear_read();

    // Parity error
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    check("perr_data", data_out, 8'h01);
    check("perr_flag", parity_err, 1);
    check("perr_ready", ready, 1);
    clear_read();

    // Overrun, then a read pulse
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("ovr_data", data_out, 8'h55);
    check("ovr_ready", ready, 1);
    check("ovr_flag", overrun, 1);
    clear_read();
    check("rd_ready", ready, 0);
    check("rd_ov", overrun, 0);

    // Reading on the delivery cycle
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check("simul_ready", ready, 1);
    check("simul_ov", overrun, 0);
    clear_read();

    // Reset mid-frame
    send_bits(32'(HDR_PATTERN), 8, 1'b0, 1'b0);
    send_bits(32'hC, 4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("mrst_ready", ready, 0);
    check("mrst_data", data_out, 0);
    check("mrst_perr", parity_err, 0);
    check("mrst_ov", overrun, 0);
    send_bits(32'b0011, 4, 1'b0, 1'b0);
    check("mrst_noreuse", ready, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    check("mrst_data2", data_out, 8'hC3);
    check("mrst_ready2", ready, 1);
    clear_read();

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          for (int k = 0; k < int'($urandom_range(1, 12)); k++) rand_bit(1'($urandom_range(0, 1)));
        end
        2: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        default: begin
          w = 8'($urandom_range(0, 255));
          for (int i = 7; i >= 0; i--) rand_bit(HDR_PATTERN[i]);
          for (int i = 7; i >= 0; i--) rand_bit(w[i]);
          rand_bit(1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
